alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Reservation station that feeds the ALU in the Tomasulo out-of-order core.
- Buffers decoded arithmetic, branch, jump and upper-immediate instructions until both source operands are available, capturing values broadcast from the ALU and LSB result buses.
- Issues one ready instruction per cycle to the ALU, which returns its result tagged with the ROB id.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_ID_W, 4, log2(RS_SIZE).
- ROB_ID_W, 4, ROB tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state holds
- rollback  in  1  misprediction flush
- dsp_valid  in  1  decoder dispatches an instruction this cycle
- dsp_opcode  in  7  opcode
- dsp_func3  in  3  func3
- dsp_func1  in  1  inst[30] (sub/sra select)
- dsp_rs1_busy  in  1  1 = rs1 waits on dsp_rs1_dep
- dsp_rs1_dep  in  ROB_ID_W  producer ROB id of rs1
- dsp_rs1_val  in  32  rs1 value when not busy
- dsp_rs2_busy, dsp_rs2_dep, dsp_rs2_val  in  1/ROB_ID_W/32  same for rs2
- dsp_imm  in  32  immediate
- dsp_off  in  32  branch/jump offset
- dsp_pc  in  32  instruction PC
- dsp_rob_target  in  ROB_ID_W  destination ROB entry
- rs_full  out  1  no free entry
- alu_cdb_valid  in  1  ALU result broadcast
- alu_cdb_rob  in  ROB_ID_W  tag
- alu_cdb_data  in  32  value
- lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_data  in  1/ROB_ID_W/32  load result broadcast
- alu_valid  out  1  issue to ALU (inst_valid)
- alu_opcode, alu_func3, alu_func1  out  7/3/1  issued fields
- alu_data1, alu_data2, alu_imm, alu_off, alu_pc  out  32 each  issued operands
- alu_rob_target  out  ROB_ID_W  issued tag

Behaviour:
- Per entry: busy, opcode, func3, func1, Q1/Q2 busy flags, Q1/Q2 dep tags, V1/V2 values, imm, off, pc, rob_target.
- Reset (rst=1 at clk edge): all busy=0; alu_valid=0; all alu_* data outputs=0. rst has priority over rollback and rdy.
- Rollback (rdy=1): all busy=0, alu_valid=0. Same-cycle dispatch and wakeup are discarded.
- rdy=0: no state or output change, including alu_valid. Held outputs must not be treated by the ALU as new issues; the ALU also stalls on rdy.
- rs_full: combinational, 1 iff all RS_SIZE entries are busy, computed from registered state. The decoder must not dispatch when rs_full=1. A dispatch while full is ignored and no entry is corrupted.
- Dispatch: written into the lowest-index free entry at the clk edge.
  - Operand bypass at dispatch: if dsp_rsX_busy and a CDB valid broadcast matches dsp_rsX_dep in the same cycle, store the CDB data with Qx busy=0.
  - When both CDBs match, LSB and ALU carry distinct tags by ROB invariant. If they do match the same tag, ALU wins.
- Wakeup: every cycle, each busy entry whose QX busy tag equals a valid CDB tag captures the data and clears QX busy. Both operands of one entry may wake in the same cycle, from the same or different buses.
- Ready: busy && !Q1busy && !Q2busy, from registered state only. An entry woken or dispatched at edge E is first selectable for edge E+1.
- Issue: at each edge, select the lowest-index ready entry.
  - If one exists: alu_valid<=1, copy its fields (V1→alu_data1, V2→alu_data2), clear its busy bit.
  - Otherwise alu_valid<=0.
  - One issue per cycle.
- Latency: dispatch with both operands ready at edge E → alu_valid high after edge E+1.
- Simultaneous issue and dispatch in one cycle: dispatch slot selection uses pre-edge busy bits. The entry freed by issue becomes available the next cycle. rs_full may therefore stay high for one extra cycle.
- Operands unused by the opcode (LUI/AUIPC/JAL) are dispatched with busy=0 by the decoder. The RS does not inspect opcode for readiness.

Test Plan:
- Reset then idle: rs_full=0, alu_valid=0 for 10 cycles; all alu_* outputs 0.
- Dispatch ADD with rs1=5 and rs2=7 both ready, rob 3, at edge E → after E+1: alu_valid=1, data1=5, data2=7, rob_target=3; after E+2: alu_valid=0.
- Dispatch with rs1 busy on rob 6. Two cycles later alu_cdb(6, 0x100) → issue on the edge after the wakeup edge with data1=0x100. Repeat with the broadcast in the dispatch cycle (bypass) → issue at E+1.
- Fill all 16 entries with operands waiting on rob 9 → rs_full=1. An extra dispatch is ignored. lsb_cdb(9) → 16 consecutive issues in index order, rs_full drops the cycle after the first issue.
- Three entries, entries 0 and 2 waiting, rollback mid-stream → next cycle alu_valid=0 and rs_full=0. A later broadcast of the old tag causes no issue.
- rdy low for 3 cycles while an entry is ready → no issue and alu_valid holds. Issue occurs on the first edge with rdy=1.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// Dispatch, result-broadcast and issue signals between the decoder, the
// result buses, the ALU and the ALU reservation station.
interface alu_reservation_station_if #(
    parameter int ROB_ID_W = 4
);
    logic                dsp_valid;
    logic [6:0]          dsp_opcode;
    logic [2:0]          dsp_func3;
    logic                dsp_func1;
    logic                dsp_rs1_busy;
    logic [ROB_ID_W-1:0] dsp_rs1_dep;
    logic [31:0]         dsp_rs1_val;
    logic                dsp_rs2_busy;
    logic [ROB_ID_W-1:0] dsp_rs2_dep;
    logic [31:0]         dsp_rs2_val;
    logic [31:0]         dsp_imm;
    logic [31:0]         dsp_off;
    logic [31:0]         dsp_pc;
    logic [ROB_ID_W-1:0] dsp_rob_target;
    logic                rs_full;

    logic                alu_cdb_valid;
    logic [ROB_ID_W-1:0] alu_cdb_rob;
    logic [31:0]         alu_cdb_data;
    logic                lsb_cdb_valid;
    logic [ROB_ID_W-1:0] lsb_cdb_rob;
    logic [31:0]         lsb_cdb_data;

    logic                alu_valid;
    logic [6:0]          alu_opcode;
    logic [2:0]          alu_func3;
    logic                alu_func1;
    logic [31:0]         alu_data1;
    logic [31:0]         alu_data2;
    logic [31:0]         alu_imm;
    logic [31:0]         alu_off;
    logic [31:0]         alu_pc;
    logic [ROB_ID_W-1:0] alu_rob_target;

    modport master (
        output dsp_valid, dsp_opcode, dsp_func3, dsp_func1,
               dsp_rs1_busy, dsp_rs1_dep, dsp_rs1_val,
               dsp_rs2_busy, dsp_rs2_dep, dsp_rs2_val,
               dsp_imm, dsp_off, dsp_pc, dsp_rob_target,
               alu_cdb_valid, alu_cdb_rob, alu_cdb_data,
               lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_data,
        input  rs_full, alu_valid, alu_opcode, alu_func3, alu_func1,
               alu_data1, alu_data2, alu_imm, alu_off, alu_pc, alu_rob_target
    );

    modport slave (
        input  dsp_valid, dsp_opcode, dsp_func3, dsp_func1,
               dsp_rs1_busy, dsp_rs1_dep, dsp_rs1_val,
               dsp_rs2_busy, dsp_rs2_dep, dsp_rs2_val,
               dsp_imm, dsp_off, dsp_pc, dsp_rob_target,
               alu_cdb_valid, alu_cdb_rob, alu_cdb_data,
               lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_data,
        output rs_full, alu_valid, alu_opcode, alu_func3, alu_func1,
               alu_data1, alu_data2, alu_imm, alu_off, alu_pc, alu_rob_target
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched instructions until both operands
// arrive from the result buses, then issues the lowest-index ready entry.
module alu_reservation_station #(
    parameter int RS_SIZE  = 16,
    parameter int RS_ID_W  = 4,
    parameter int ROB_ID_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback,
    alu_reservation_station_if.slave  bus
);

    logic [RS_SIZE-1:0]  busy_r;
    logic [RS_SIZE-1:0]  q1_busy_r;
    logic [RS_SIZE-1:0]  q2_busy_r;
    logic [RS_SIZE-1:0]  func1_r;
    logic [6:0]          opcode_r [RS_SIZE];
    logic [2:0]          func3_r  [RS_SIZE];
    logic [ROB_ID_W-1:0] q1_dep_r [RS_SIZE];
    logic [ROB_ID_W-1:0] q2_dep_r [RS_SIZE];
    logic [ROB_ID_W-1:0] rob_r    [RS_SIZE];
    logic [31:0]         v1_r     [RS_SIZE];
    logic [31:0]         v2_r     [RS_SIZE];
    logic [31:0]         imm_r    [RS_SIZE];
    logic [31:0]         off_r    [RS_SIZE];
    logic [31:0]         pc_r     [RS_SIZE];

    logic                alu_valid_r;
    logic [6:0]          alu_opcode_r;
    logic [2:0]          alu_func3_r;
    logic                alu_func1_r;
    logic [31:0]         alu_data1_r;
    logic [31:0]         alu_data2_r;
    logic [31:0]         alu_imm_r;
    logic [31:0]         alu_off_r;
    logic [31:0]         alu_pc_r;
    logic [ROB_ID_W-1:0] alu_rob_target_r;

    logic [RS_SIZE-1:0]  ready_vec_s;
    logic [RS_ID_W-1:0]  free_idx_s;
    logic [RS_ID_W-1:0]  ready_idx_s;
    logic                rs_full_s;
    logic                ready_found_s;
    logic                dsp_accept_s;
    logic [32:0]         dsp_op1_s;
    logic [32:0]         dsp_op2_s;
    logic [32:0]         op1_wake_s [RS_SIZE];
    logic [32:0]         op2_wake_s [RS_SIZE];

    // Returns {still_busy, value}; the ALU bus wins if both buses carry the tag.
    function automatic logic [32:0] capture_operand(
        input logic                q_busy,
        input logic [ROB_ID_W-1:0] q_dep,
        input logic [31:0]         q_val,
        input logic                a_valid,
        input logic [ROB_ID_W-1:0] a_rob,
        input logic [31:0]         a_data,
        input logic                l_valid,
        input logic [ROB_ID_W-1:0] l_rob,
        input logic [31:0]         l_data
    );
        logic [32:0] result;
        if (!q_busy) begin
            result = {1'b0, q_val};
        end else if (a_valid && (a_rob == q_dep)) begin
            result = {1'b0, a_data};
        end else if (l_valid && (l_rob == q_dep)) begin
            result = {1'b0, l_data};
        end else begin
            result = {1'b1, q_val};
        end
        return result;
    endfunction

    assign ready_vec_s   = busy_r & ~q1_busy_r & ~q2_busy_r;
    assign rs_full_s     = &busy_r;
    assign ready_found_s = |ready_vec_s;
    assign dsp_accept_s  = bus.dsp_valid && !rs_full_s;

    // Lowest-index free slot and lowest-index ready entry (descending scan, last hit wins).
    always_comb begin
        free_idx_s  = {RS_ID_W{1'b0}};
        ready_idx_s = {RS_ID_W{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            free_idx_s  = busy_r[i]      ? free_idx_s  : RS_ID_W'(i);
            ready_idx_s = ready_vec_s[i] ? RS_ID_W'(i) : ready_idx_s;
        end
    end

    // Operand capture for the incoming dispatch and for every stored entry.
    always_comb begin
        dsp_op1_s = capture_operand(bus.dsp_rs1_busy, bus.dsp_rs1_dep, bus.dsp_rs1_val,
                                    bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_data,
                                    bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_data);
        dsp_op2_s = capture_operand(bus.dsp_rs2_busy, bus.dsp_rs2_dep, bus.dsp_rs2_val,
                                    bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_data,
                                    bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_data);
        for (int i = 0; i < RS_SIZE; i++) begin
            op1_wake_s[i] = capture_operand(q1_busy_r[i], q1_dep_r[i], v1_r[i],
                                            bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_data,
                                            bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_data);
            op2_wake_s[i] = capture_operand(q2_busy_r[i], q2_dep_r[i], v2_r[i],
                                            bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_data,
                                            bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_data);
        end
    end

    // Entry storage: wakeup, issue release and dispatch write (dispatch slot uses pre-edge busy).
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {RS_SIZE{1'b0}};
        end else if (rdy) begin
            if (rollback) begin
                busy_r <= {RS_SIZE{1'b0}};
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_r[i]) begin
                        {q1_busy_r[i], v1_r[i]} <= op1_wake_s[i];
                        {q2_busy_r[i], v2_r[i]} <= op2_wake_s[i];
                    end
                end
                if (ready_found_s) begin
                    busy_r[ready_idx_s] <= 1'b0;
                end
                if (dsp_accept_s) begin
                    busy_r[free_idx_s]   <= 1'b1;
                    opcode_r[free_idx_s] <= bus.dsp_opcode;
                    func3_r[free_idx_s]  <= bus.dsp_func3;
                    func1_r[free_idx_s]  <= bus.dsp_func1;
                    q1_dep_r[free_idx_s] <= bus.dsp_rs1_dep;
                    q2_dep_r[free_idx_s] <= bus.dsp_rs2_dep;
                    {q1_busy_r[free_idx_s], v1_r[free_idx_s]} <= dsp_op1_s;
                    {q2_busy_r[free_idx_s], v2_r[free_idx_s]} <= dsp_op2_s;
                    imm_r[free_idx_s]    <= bus.dsp_imm;
                    off_r[free_idx_s]    <= bus.dsp_off;
                    pc_r[free_idx_s]     <= bus.dsp_pc;
                    rob_r[free_idx_s]    <= bus.dsp_rob_target;
                end
            end
        end
    end

    // Issue register toward the ALU; fields hold when nothing is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_valid_r      <= 1'b0;
            alu_opcode_r     <= 7'd0;
            alu_func3_r      <= 3'd0;
            alu_func1_r      <= 1'b0;
            alu_data1_r      <= 32'd0;
            alu_data2_r      <= 32'd0;
            alu_imm_r        <= 32'd0;
            alu_off_r        <= 32'd0;
            alu_pc_r         <= 32'd0;
            alu_rob_target_r <= {ROB_ID_W{1'b0}};
        end else if (rdy) begin
            if (rollback) begin
                alu_valid_r <= 1'b0;
            end else if (ready_found_s) begin
                alu_valid_r      <= 1'b1;
                alu_opcode_r     <= opcode_r[ready_idx_s];
                alu_func3_r      <= func3_r[ready_idx_s];
                alu_func1_r      <= func1_r[ready_idx_s];
                alu_data1_r      <= v1_r[ready_idx_s];
                alu_data2_r      <= v2_r[ready_idx_s];
                alu_imm_r        <= imm_r[ready_idx_s];
                alu_off_r        <= off_r[ready_idx_s];
                alu_pc_r         <= pc_r[ready_idx_s];
                alu_rob_target_r <= rob_r[ready_idx_s];
            end else begin
                alu_valid_r <= 1'b0;
            end
        end
    end

    assign bus.rs_full        = rs_full_s;
    assign bus.alu_valid      = alu_valid_r;
    assign bus.alu_opcode     = alu_opcode_r;
    assign bus.alu_func3      = alu_func3_r;
    assign bus.alu_func1      = alu_func1_r;
    assign bus.alu_data1      = alu_data1_r;
    assign bus.alu_data2      = alu_data2_r;
    assign bus.alu_imm        = alu_imm_r;
    assign bus.alu_off        = alu_off_r;
    assign bus.alu_pc         = alu_pc_r;
    assign bus.alu_rob_target = alu_rob_target_r;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected issues are queued at
// dispatch/broadcast time and compared, including issue cycle, when the ALU port fires.
module tb_alu_reservation_station;

    localparam logic [6:0]  OP_ADD = 7'b0110011;
    localparam logic [6:0]  OP_BR  = 7'b1100011;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f1;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] off;
        logic [31:0] pc;
        logic [3:0]  rob;
        int          when;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;
    logic rdy_edge = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pc_ctr = 0;
    exp_t last_d;
    exp_t mon_e;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_reservation_station_if #(.ROB_ID_W(4)) bus ();

    alu_reservation_station #(.RS_SIZE(16), .RS_ID_W(4), .ROB_ID_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdy_edge <= rdy && !rst;
    end

    // Scoreboard: every fresh issue must match the oldest expected entry, in its cycle.
    always @(negedge clk) begin
        if (rdy_edge && bus.alu_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_issue", {31'd0, bus.alu_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("issue_cycle", cyc, mon_e.when);
                check_val("issue_rob", {28'd0, bus.alu_rob_target}, {28'd0, mon_e.rob});
                check_val("issue_data1", bus.alu_data1, mon_e.d1);
                check_val("issue_data2", bus.alu_data2, mon_e.d2);
                check_val("issue_opcode", {25'd0, bus.alu_opcode}, {25'd0, mon_e.op});
                check_val("issue_func", {28'd0, bus.alu_func1, bus.alu_func3},
                          {28'd0, mon_e.f1, mon_e.f3});
                check_val("issue_imm", bus.alu_imm, mon_e.imm);
                check_val("issue_off", bus.alu_off, mon_e.off);
                check_val("issue_pc", bus.alu_pc, mon_e.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.dsp_valid     = 1'b0;
        bus.alu_cdb_valid = 1'b0;
        bus.lsb_cdb_valid = 1'b0;
        rollback          = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic dispatch(input logic b1, input logic [3:0] d1, input logic [31:0] v1,
                            input logic b2, input logic [3:0] d2, input logic [31:0] v2,
                            input logic [3:0] rob);
        pc_ctr++;
        last_d.op  = rob[0] ? OP_BR : OP_ADD;
        last_d.f3  = rob[2:0];
        last_d.f1  = rob[3];
        last_d.imm = 32'h0001_0000 + 32'(pc_ctr);
        last_d.off = 32'hFFFF_0000 - 32'(pc_ctr);
        last_d.pc  = 32'h0000_4000 + 32'(pc_ctr * 4);
        last_d.rob = rob;
        bus.dsp_valid      = 1'b1;
        bus.dsp_opcode     = last_d.op;
        bus.dsp_func3      = last_d.f3;
        bus.dsp_func1      = last_d.f1;
        bus.dsp_rs1_busy   = b1;
        bus.dsp_rs1_dep    = d1;
        bus.dsp_rs1_val    = v1;
        bus.dsp_rs2_busy   = b2;
        bus.dsp_rs2_dep    = d2;
        bus.dsp_rs2_val    = v2;
        bus.dsp_imm        = last_d.imm;
        bus.dsp_off        = last_d.off;
        bus.dsp_pc         = last_d.pc;
        bus.dsp_rob_target = rob;
    endtask

    task automatic push(input logic [31:0] d1, input logic [31:0] d2, input int when);
        exp_t e;
        e      = last_d;
        e.d1   = d1;
        e.d2   = d2;
        e.when = when;
        sb_q.push_back(e);
    endtask

    task automatic alu_cdb(input logic [3:0] r, input logic [31:0] d);
        bus.alu_cdb_valid = 1'b1;
        bus.alu_cdb_rob   = r;
        bus.alu_cdb_data  = d;
    endtask

    task automatic lsb_cdb(input logic [3:0] r, input logic [31:0] d);
        bus.lsb_cdb_valid = 1'b1;
        bus.lsb_cdb_rob   = r;
        bus.lsb_cdb_data  = d;
    endtask

    initial begin
        int f;
        rst = 1'b1;
        rdy = 1'b1;
        rollback = 1'b0;
        bus.dsp_valid = 1'b0;
        bus.alu_cdb_valid = 1'b0;
        bus.lsb_cdb_valid = 1'b0;
        dispatch(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0);
        bus.dsp_valid = 1'b0;
        alu_cdb(4'd0, 32'd0);
        lsb_cdb(4'd0, 32'd0);
        ticks(2);
        rst = 1'b0;

        // Reset state and idle
        check_val("rst_valid", {31'd0, bus.alu_valid}, 32'd0);
        check_val("rst_data1", bus.alu_data1, 32'd0);
        check_val("rst_data2", bus.alu_data2, 32'd0);
        check_val("rst_imm_off_pc", bus.alu_imm | bus.alu_off | bus.alu_pc, 32'd0);
        check_val("rst_fields", {21'd0, bus.alu_opcode, bus.alu_func3, bus.alu_func1},
                  32'd0);
        check_val("rst_rob", {28'd0, bus.alu_rob_target}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("idle_full", {31'd0, bus.rs_full}, 32'd0);
            check_val("idle_valid", {31'd0, bus.alu_valid}, 32'd0);
        end

        // Ready ADD: issue one edge after dispatch, then drop
        dispatch(1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
        push(32'd5, 32'd7, cyc + 2);
        tick();
        check_val("add_not_yet", {31'd0, bus.alu_valid}, 32'd0);
        tick();
        check_val("add_valid", {31'd0, bus.alu_valid}, 32'd1);
        check_val("add_data1", bus.alu_data1, 32'd5);
        check_val("add_data2", bus.alu_data2, 32'd7);
        tick();
        check_val("add_valid_drop", {31'd0, bus.alu_valid}, 32'd0);

        // Wakeup two cycles after dispatch
        dispatch(1'b1, 4'd6, JUNK, 1'b0, 4'd0, 32'h22, 4'd4);
        push(32'h100, 32'h22, cyc + 4);
        ticks(2);
        check_val("wake_wait", {31'd0, bus.alu_valid}, 32'd0);
        alu_cdb(4'd6, 32'h100);
        tick();
        check_val("wake_edge_noissue", {31'd0, bus.alu_valid}, 32'd0);
        tick();
        check_val("wake_issue_data1", bus.alu_data1, 32'h100);

        // Bypass at dispatch: ALU bus, both buses, same tag on both buses
        dispatch(1'b1, 4'd6, JUNK, 1'b0, 4'd0, 32'h33, 4'd5);
        alu_cdb(4'd6, 32'h200);
        push(32'h200, 32'h33, cyc + 2);
        ticks(2);
        dispatch(1'b1, 4'd7, JUNK, 1'b1, 4'd8, JUNK, 4'd6);
        alu_cdb(4'd7, 32'h71);
        lsb_cdb(4'd8, 32'h82);
        push(32'h71, 32'h82, cyc + 2);
        ticks(2);
        dispatch(1'b1, 4'd5, JUNK, 1'b0, 4'd0, 32'd1, 4'd7);
        alu_cdb(4'd5, 32'hAA);
        lsb_cdb(4'd5, 32'hBB);
        push(32'hAA, 32'd1, cyc + 2);
        ticks(2);

        // Wakeup of both operands from different buses, then same-tag priority
        dispatch(1'b1, 4'd11, JUNK, 1'b1, 4'd12, JUNK, 4'd8);
        push(32'hB1, 32'hC2, cyc + 3);
        tick();
        alu_cdb(4'd11, 32'hB1);
        lsb_cdb(4'd12, 32'hC2);
        ticks(2);
        dispatch(1'b1, 4'd13, JUNK, 1'b0, 4'd0, 32'd2, 4'd9);
        push(32'hCC, 32'd2, cyc + 3);
        tick();
        alu_cdb(4'd13, 32'hCC);
        lsb_cdb(4'd13, 32'hDD);
        ticks(3);

        // Fill all entries waiting on rob 9, overflow dispatch, then drain in order
        f = cyc + 1;
        for (int i = 0; i < 16; i++) begin
            dispatch(1'b1, 4'd9, JUNK ^ 32'(i), 1'b0, 4'd0, 32'h500 + 32'(i), 4'(i));
            push(32'h900, 32'h500 + 32'(i), f + 18 + i);
            tick();
        end
        check_val("fill_full", {31'd0, bus.rs_full}, 32'd1);
        dispatch(1'b0, 4'd0, 32'hBAD0, 1'b0, 4'd0, 32'hBAD1, 4'd15);
        tick();
        check_val("overflow_full", {31'd0, bus.rs_full}, 32'd1);
        check_val("overflow_noissue", {31'd0, bus.alu_valid}, 32'd0);
        lsb_cdb(4'd9, 32'h900);
        tick();
        check_val("wake_still_full", {31'd0, bus.rs_full}, 32'd1);
        tick();
        check_val("full_drop", {31'd0, bus.rs_full}, 32'd0);
        check_val("drain_valid", {31'd0, bus.alu_valid}, 32'd1);
        ticks(15);
        tick();
        check_val("drain_done", {31'd0, bus.alu_valid}, 32'd0);

        // Rollback with entries 0 and 2 waiting, entry 1 issued
        dispatch(1'b1, 4'd10, JUNK, 1'b0, 4'd0, 32'd1, 4'd1);
        tick();
        dispatch(1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h12, 4'd2);
        push(32'h11, 32'h12, cyc + 2);
        tick();
        dispatch(1'b1, 4'd10, JUNK, 1'b0, 4'd0, 32'd3, 4'd3);
        tick();
        check_val("rb_pre_valid", {31'd0, bus.alu_valid}, 32'd1);
        rollback = 1'b1;
        dispatch(1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'h78, 4'd4);
        alu_cdb(4'd10, 32'h1010);
        tick();
        check_val("rb_valid", {31'd0, bus.alu_valid}, 32'd0);
        check_val("rb_full", {31'd0, bus.rs_full}, 32'd0);
        alu_cdb(4'd10, 32'h1010);
        ticks(3);
        check_val("rb_old_tag_noissue", {31'd0, bus.alu_valid}, 32'd0);

        // rdy low for three cycles while an entry is ready
        dispatch(1'b0, 4'd0, 32'h51, 1'b0, 4'd0, 32'h52, 4'd5);
        push(32'h51, 32'h52, cyc + 2);
        tick();
        dispatch(1'b0, 4'd0, 32'h61, 1'b0, 4'd0, 32'h62, 4'd6);
        push(32'h61, 32'h62, cyc + 5);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_valid_hold", {31'd0, bus.alu_valid}, 32'd1);
            check_val("stall_rob_hold", {28'd0, bus.alu_rob_target}, 32'd5);
        end
        rdy = 1'b1;
        tick();
        check_val("resume_rob", {28'd0, bus.alu_rob_target}, 32'd6);
        tick();
        check_val("resume_drop", {31'd0, bus.alu_valid}, 32'd0);

        ticks(3);
        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
